// File: rtl/capture_trigger_pkg.sv
// Shared definitions for the capture/trigger stage: state encodings, sample-word
// field layout and a counter-sizing helper.
package capture_trigger_pkg;

  localparam int ADC_W   = 14;
  localparam int CH0_LSB = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  typedef logic signed [ADC_W-1:0] adc_t;

  // Width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic adc_t ch0_of(input logic [31:0] word);
    return adc_t'(word[CH0_LSB +: ADC_W]);
  endfunction

endpackage

// File: rtl/capture_trigger_sample_decimator.sv
// Keeps 1 of (decim_i+1) valid strobes. The ratio is latched at the start of each
// period, so a change mid-period takes effect only after the next wrap.
module sample_decimator #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] decim_i,
  input  logic          valid_i,
  output logic          keep_o
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] ratio_q, ratio_d;
  logic [DW-1:0] ratio_eff;

  assign ratio_eff = (cnt_q == '0) ? decim_i : ratio_q;
  assign keep_o    = valid_i && (cnt_q == ratio_eff);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    if (valid_i) begin
      if (cnt_q == '0) ratio_d = decim_i;
      cnt_d = keep_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ratio_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
    end
  end

endmodule

// File: rtl/capture_trigger.sv
// Trigger and capture-window stage: decimates the sample stream, triggers on a
// channel-0 level crossing (or auto timeout) and forwards CAP_LEN samples to the FIFO.
module capture_trigger
  import capture_trigger_pkg::*;
#(
  parameter int CAP_LEN      = 1024,
  parameter int HOLDOFF      = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             continuous,
  input  logic             auto_mode,
  input  logic             trig_slope,
  input  logic [ADC_W-1:0] trig_level,
  input  logic [7:0]       decim,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  input  logic             fifo_full,
  output logic [31:0]      fifo_din,
  output logic             fifo_wr_en,
  output logic [1:0]       state_o,
  output logic             triggered,
  output logic [15:0]      ovf_cnt
);

  localparam int CW = cnt_width(CAP_LEN);
  localparam int HW = cnt_width(HOLDOFF);
  localparam int TW = cnt_width(AUTO_TIMEOUT);

  localparam logic [CW-1:0] CAP_LAST = CW'((CAP_LEN > 0) ? CAP_LEN - 1 : 0);
  localparam logic [HW-1:0] HO_LAST  = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);

  logic [1:0]    state_q, state_d;
  adc_t          prev_q, prev_d;
  logic          pv_q, pv_d;
  logic [TW-1:0] to_q, to_d;
  logic [CW-1:0] cap_q, cap_d;
  logic [HW-1:0] ho_q, ho_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [31:0]   din_q, din_d;
  logic          wr_q, wr_d;
  logic          trig_q, trig_d;

  logic keep;
  adc_t cur, level;
  logic hit, forced, first_sample, take_sample, capture_done, leave_holdoff;

  sample_decimator #(.DW(8)) u_decim (
    .clk     (clk),
    .rst     (rst),
    .decim_i (decim),
    .valid_i (s_valid),
    .keep_o  (keep)
  );

  assign cur   = ch0_of(s_data);
  assign level = adc_t'(trig_level);

  always_comb begin
    if (trig_slope) hit = pv_q && (prev_q > level) && (cur <= level);
    else            hit = pv_q && (prev_q < level) && (cur >= level);
  end

  assign forced        = auto_mode && (to_q >= TO_LAST);
  assign first_sample  = (state_q == ST_ARMED) && keep && (hit || forced);
  assign take_sample   = first_sample || ((state_q == ST_CAPTURE) && keep);
  assign capture_done  = take_sample && (first_sample ? (CAP_LEN <= 1) : (cap_q == CAP_LAST));
  assign leave_holdoff = (capture_done && (HOLDOFF == 0)) ||
                         ((state_q == ST_HOLDOFF) && keep && (ho_q == HO_LAST));

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    to_d    = to_q;
    cap_d   = cap_q;
    ho_d    = ho_q;
    ovf_d   = ovf_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    trig_d  = first_sample;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          pv_d    = 1'b0;
          to_d    = '0;
        end
      end
      ST_ARMED: begin
        if (keep) begin
          prev_d = cur;
          pv_d   = 1'b1;
          to_d   = to_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (keep) ho_d = ho_q + 1'b1;
      end
      default: ;
    endcase

    // Sample 0 of a record is the triggering sample itself.
    if (take_sample) begin
      if (!fifo_full) begin
        wr_d  = 1'b1;
        din_d = s_data;
      end else if (ovf_q != 16'hFFFF) begin
        ovf_d = ovf_q + 16'd1;
      end
      state_d = ST_CAPTURE;
      cap_d   = first_sample ? CW'(1) : cap_q + 1'b1;
    end

    if (capture_done) begin
      state_d = ST_HOLDOFF;
      ho_d    = '0;
    end

    if (leave_holdoff) begin
      if (continuous) begin
        state_d = ST_ARMED;
        pv_d    = 1'b0;
        to_d    = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      to_q    <= '0;
      cap_q   <= '0;
      ho_q    <= '0;
      ovf_q   <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      to_q    <= to_d;
      cap_q   <= cap_d;
      ho_q    <= ho_d;
      ovf_q   <= ovf_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      trig_q  <= trig_d;
    end
  end

  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_q;
  assign state_o    = state_q;
  assign triggered  = trig_q;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Directed bench for capture_trigger with a write scoreboard: expected FIFO words
// are queued as stimulus is planned and popped whenever the DUT writes.
module tb_capture_trigger;

  localparam int CAP_LEN      = 8;
  localparam int HOLDOFF      = 4;
  localparam int AUTO_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        continuous = 1'b0;
  logic        auto_mode = 1'b0;
  logic        trig_slope = 1'b0;
  logic [13:0] trig_level = '0;
  logic [7:0]  decim = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic [1:0]  state_o;
  logic        triggered;
  logic [15:0] ovf_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_trig = 0;
  int w0, t0;
  logic prev_wr = 1'b0;
  logic [31:0] exp_q[$];

  capture_trigger #(
    .CAP_LEN      (CAP_LEN),
    .HOLDOFF      (HOLDOFF),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .continuous (continuous),
    .auto_mode  (auto_mode),
    .trig_slope (trig_slope),
    .trig_level (trig_level),
    .decim      (decim),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .state_o    (state_o),
    .triggered  (triggered),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkword(input int v);
    logic signed [13:0] c0;
    c0 = 14'(v);
    return {2'b00, c0, 2'b00, ~c0};
  endfunction

  // Scoreboard side: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en) begin
        check("wr_back_to_back", 32'(prev_wr), 32'd0);
        check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("wr_data", fifo_din, exp_q.pop_front());
        n_wr++;
      end
      if (triggered) n_trig++;
      prev_wr = fifo_wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic strobe(input int v);
    @(negedge clk);
    s_data  = mkword(v);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    #1;
  endtask

  task automatic expect_range(input int lo, input int hi, input int step);
    for (int v = lo; v <= hi; v += step) exp_q.push_back(mkword(v));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_din", fifo_din, 32'd0);
    check("rst_trig", 32'(triggered), 32'd0);
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    rst = 1'b0;

    // 1: rising through 0 on a -100..+100 ramp
    pulse_arm();
    check("t1_armed", 32'(state_o), 32'd1);
    w0 = n_wr; t0 = n_trig;
    expect_range(0, CAP_LEN - 1, 1);
    for (int v = -100; v <= 100; v++) strobe(v);
    check("t1_writes", 32'(n_wr - w0), 32'(CAP_LEN));
    check("t1_trig", 32'(n_trig - t0), 32'd1);
    check("t1_queue", 32'(exp_q.size()), 32'd0);
    check("t1_idle", 32'(state_o), 32'd0);

    // 2: decim=3, prime one kept sample below level, then 40 strobes
    decim = 8'd3;
    pulse_arm();
    for (int k = 1; k <= 4; k++) strobe(-10);
    w0 = n_wr; t0 = n_trig;
    expect_range(4, 32, 4);
    for (int k = 1; k <= 40; k++) strobe(k);
    check("t2_writes", 32'(n_wr - w0), 32'd8);
    check("t2_trig", 32'(n_trig - t0), 32'd1);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    check("t2_holdoff", 32'(state_o), 32'd3);
    for (int k = 41; k <= 48; k++) strobe(k);
    check("t2_idle", 32'(state_o), 32'd0);
    decim = 8'd0;

    // 3: falling through -50
    trig_slope = 1'b1;
    trig_level = 14'(-50);
    pulse_arm();
    w0 = n_wr; t0 = n_trig;
    for (int k = 0; k < 10; k++) strobe(200);
    check("t3_no_trig", 32'(n_trig - t0), 32'd0);
    check("t3_armed", 32'(state_o), 32'd1);
    for (int k = 0; k < CAP_LEN; k++) exp_q.push_back(mkword(-60));
    for (int k = 0; k < CAP_LEN + HOLDOFF; k++) strobe(-60);
    check("t3_writes", 32'(n_wr - w0), 32'(CAP_LEN));
    check("t3_trig", 32'(n_trig - t0), 32'd1);
    check("t3_idle", 32'(state_o), 32'd0);

    // 4: auto trigger on the 16th kept sample of a non-crossing input
    trig_slope = 1'b0;
    trig_level = 14'd0;
    auto_mode  = 1'b1;
    pulse_arm();
    w0 = n_wr; t0 = n_trig;
    for (int k = 1; k < AUTO_TIMEOUT; k++) strobe(-k);
    check("t4_no_trig", 32'(n_trig - t0), 32'd0);
    check("t4_armed", 32'(state_o), 32'd1);
    for (int k = AUTO_TIMEOUT; k < AUTO_TIMEOUT + CAP_LEN; k++) exp_q.push_back(mkword(-k));
    for (int k = AUTO_TIMEOUT; k < AUTO_TIMEOUT + CAP_LEN + HOLDOFF; k++) strobe(-k);
    check("t4_writes", 32'(n_wr - w0), 32'(CAP_LEN));
    check("t4_trig", 32'(n_trig - t0), 32'd1);
    check("t4_idle", 32'(state_o), 32'd0);
    auto_mode = 1'b0;

    // 5: fifo_full during capture samples 3..7
    pulse_arm();
    strobe(-1);
    w0 = n_wr;
    exp_q.push_back(mkword(1));
    exp_q.push_back(mkword(2));
    exp_q.push_back(mkword(8));
    for (int v = 1; v <= CAP_LEN; v++) begin
      fifo_full = (v >= 3 && v <= 7);
      strobe(v);
    end
    fifo_full = 1'b0;
    check("t5_writes", 32'(n_wr - w0), 32'd3);
    check("t5_ovf", 32'(ovf_cnt), 32'd5);
    check("t5_holdoff", 32'(state_o), 32'd3);
    for (int k = 0; k < HOLDOFF; k++) strobe(0);
    check("t5_idle", 32'(state_o), 32'd0);

    // 6: continuous re-arm after holdoff, then reset mid-capture
    continuous = 1'b1;
    pulse_arm();
    strobe(-1);
    w0 = n_wr;
    expect_range(1, CAP_LEN, 1);
    for (int v = 1; v <= CAP_LEN; v++) strobe(v);
    check("t6_writes", 32'(n_wr - w0), 32'(CAP_LEN));
    for (int k = 0; k < HOLDOFF - 1; k++) strobe(0);
    check("t6_still_holdoff", 32'(state_o), 32'd3);
    strobe(0);
    check("t6_rearmed", 32'(state_o), 32'd1);
    strobe(-1);
    expect_range(3, 5, 1);
    for (int v = 3; v <= 5; v++) strobe(v);
    check("t6_capture", 32'(state_o), 32'd2);
    @(negedge clk);
    s_data  = mkword(6);
    s_valid = 1'b1;
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(state_o), 32'd0);
    check("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("t6_rst_din", fifo_din, 32'd0);
    check("t6_rst_trig", 32'(triggered), 32'd0);
    check("t6_rst_ovf", 32'(ovf_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Clean record after the abandoned one
    pulse_arm();
    strobe(-1);
    w0 = n_wr;
    expect_range(11, 10 + CAP_LEN, 1);
    for (int v = 11; v <= 10 + CAP_LEN; v++) strobe(v);
    check("t6_clean_writes", 32'(n_wr - w0), 32'(CAP_LEN));
    check("t6_clean_holdoff", 32'(state_o), 32'd3);
    check("t6_clean_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
